// File: rtl/fpu_muldiv_arb.sv
// Two-requester round-robin controller for a shared FMUL/FDIV datapath.
// Muls stream one per cycle; a div drains the pipe and then runs alone.
module fpu_muldiv_arb #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 26,
  parameter int unsigned TAG_W   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][2:0]       req_op,
  input  logic [1:0][31:0]      req_opa,
  input  logic [1:0][31:0]      req_opb,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic                  dp_start,
  output logic [2:0]            dp_op,
  output logic [31:0]           dp_opa,
  output logic [31:0]           dp_opb,
  input  logic [31:0]           dp_result,
  output logic                  rsp_valid,
  output logic                  rsp_id,
  output logic [TAG_W-1:0]      rsp_tag,
  output logic [31:0]           rsp_result,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam int unsigned CNT_W  = $clog2(MUL_LAT + 2) + 1;
  localparam int unsigned DCNT_W = $clog2(DIV_LAT + 2);
  localparam logic [DCNT_W-1:0] DIV_LOAD = DCNT_W'(DIV_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DIV} state_t;

  typedef struct packed {
    logic             vld;
    logic             id;
    logic [TAG_W-1:0] tag;
    logic             err;
  } trk_t;

  state_t              r_state;
  logic                r_rr;
  logic                r_lock_vld;
  logic                r_lock_id;
  logic [CNT_W-1:0]    r_cnt;
  logic [DCNT_W-1:0]   r_div_cnt;
  logic                r_div_id;
  logic [TAG_W-1:0]    r_div_tag;
  trk_t                r_pipe [0:MUL_LAT];

  logic                w_cand_id;
  logic                w_cand_vld;
  logic [2:0]          w_cand_op;
  logic                w_cand_div;
  logic                w_cand_err;
  logic                w_rdy_en;
  logic                w_xfer;
  logic                w_mul_smp;
  logic                w_div_smp;
  logic                w_smp;
  logic [CNT_W-1:0]    w_cnt_nxt;
  trk_t                w_push;

  // Candidate: a locked (stalled) port wins, else the single valid port, else rr.
  always_comb begin
    w_cand_id = 1'b0;
    if (r_lock_vld) begin
      w_cand_id = r_lock_id;
    end else if (&req_valid) begin
      w_cand_id = r_rr;
    end else begin
      w_cand_id = req_valid[1];
    end
    w_cand_vld = req_valid[w_cand_id];
    w_cand_op  = req_op[w_cand_id];
    w_cand_div = (w_cand_op == OP_DIV);
    w_cand_err = (w_cand_op != OP_MUL) && (w_cand_op != OP_DIV);
  end

  // Ready gating per state; a div in RUN forces a drain before it is taken.
  always_comb begin
    w_rdy_en = 1'b0;
    case (r_state)
      S_IDLE:  w_rdy_en = w_cand_vld;
      S_RUN:   w_rdy_en = w_cand_vld && !w_cand_div;
      S_DRAIN: w_rdy_en = w_cand_vld && (r_cnt == '0) && !dp_start;
      S_DIV:   w_rdy_en = 1'b0;
      default: w_rdy_en = 1'b0;
    endcase
  end

  assign w_xfer    = reset_n & w_rdy_en;
  assign req_ready = w_xfer ? (w_cand_id ? 2'b10 : 2'b01) : 2'b00;

  assign w_mul_smp = r_pipe[MUL_LAT].vld;
  assign w_div_smp = (r_div_cnt == DCNT_W'(1));
  assign w_smp     = w_mul_smp | w_div_smp;
  assign w_cnt_nxt = r_cnt + CNT_W'(dp_start) - CNT_W'(w_smp);

  always_comb begin
    w_push     = '0;
    w_push.vld = w_xfer & ~w_cand_div;
    w_push.id  = w_cand_id;
    w_push.tag = req_tag[w_cand_id];
    w_push.err = w_cand_err;
  end

  assign busy = (r_state != S_IDLE) | (r_cnt != '0) | rsp_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rr       <= 1'b0;
      r_lock_vld <= 1'b0;
      r_lock_id  <= 1'b0;
      r_cnt      <= '0;
      r_div_cnt  <= '0;
      r_div_id   <= 1'b0;
      r_div_tag  <= '0;
      for (int i = 0; i <= int'(MUL_LAT); i++) begin
        r_pipe[i] <= '0;
      end
      dp_start   <= 1'b0;
      dp_op      <= '0;
      dp_opa     <= '0;
      dp_opb     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_tag    <= '0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      // Pointer flips only on a transfer; a stalled candidate stays locked.
      if (w_xfer) begin
        r_rr       <= ~w_cand_id;
        r_lock_vld <= 1'b0;
      end else if (w_cand_vld) begin
        r_lock_vld <= 1'b1;
        r_lock_id  <= w_cand_id;
      end

      dp_start <= w_xfer;
      if (w_xfer) begin
        dp_op  <= w_cand_op;
        dp_opa <= req_opa[w_cand_id];
        dp_opb <= req_opb[w_cand_id];
      end

      // Entry 0 lines up with dp_start, so entry MUL_LAT is the sample cycle.
      r_pipe[0] <= w_push;
      for (int i = 1; i <= int'(MUL_LAT); i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end

      if (w_xfer && w_cand_div) begin
        r_div_cnt <= DIV_LOAD;
        r_div_id  <= w_cand_id;
        r_div_tag <= req_tag[w_cand_id];
      end else if (r_div_cnt != '0) begin
        r_div_cnt <= r_div_cnt - DCNT_W'(1);
      end

      r_cnt     <= w_cnt_nxt;
      rsp_valid <= w_smp;
      if (w_mul_smp) begin
        rsp_id     <= r_pipe[MUL_LAT].id;
        rsp_tag    <= r_pipe[MUL_LAT].tag;
        rsp_err    <= r_pipe[MUL_LAT].err;
        rsp_result <= dp_result;
      end else if (w_div_smp) begin
        rsp_id     <= r_div_id;
        rsp_tag    <= r_div_tag;
        rsp_err    <= 1'b0;
        rsp_result <= dp_result;
      end

      case (r_state)
        S_IDLE: begin
          if (w_xfer) r_state <= w_cand_div ? S_DIV : S_RUN;
        end
        S_RUN: begin
          if (w_cand_vld && w_cand_div) begin
            r_state <= S_DRAIN;
          end else if (!w_xfer && (w_cnt_nxt == '0)) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (w_xfer) r_state <= w_cand_div ? S_DIV : S_RUN;
        end
        S_DIV: begin
          if (w_div_smp) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_muldiv_arb.sv
// Directed bench for fpu_muldiv_arb; the datapath stub returns a per-cycle stamp
// so each response proves the exact cycle its result was sampled.
module tb_fpu_muldiv_arb;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned DIV_LAT = 26;
  localparam int unsigned TAG_W   = 4;
  localparam logic [2:0]  OP_MUL  = 3'b010;
  localparam logic [2:0]  OP_DIV  = 3'b011;

  logic                  clk;
  logic                  reset_n;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0][2:0]       req_op;
  logic [1:0][31:0]      req_opa;
  logic [1:0][31:0]      req_opb;
  logic [1:0][TAG_W-1:0] req_tag;
  logic                  dp_start;
  logic [2:0]            dp_op;
  logic [31:0]           dp_opa;
  logic [31:0]           dp_opb;
  logic [31:0]           dp_result;
  logic                  rsp_valid;
  logic                  rsp_id;
  logic [TAG_W-1:0]      rsp_tag;
  logic [31:0]           rsp_result;
  logic                  rsp_err;
  logic                  busy;

  fpu_muldiv_arb #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .dp_start(dp_start), .dp_op(dp_op), .dp_opa(dp_opa), .dp_opb(dp_opb),
    .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    int               c;
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [31:0]      res;
    logic             err;
  } rsp_t;

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dp_fix_cyc = -1;
  logic [31:0] dp_fix_val = '0;
  rsp_t        rsp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] stamp(input int c);
    return 32'hD500_0000 | 32'(c);
  endfunction

  assign dp_result = (cyc == dp_fix_cyc) ? dp_fix_val : stamp(cyc);

  always @(negedge clk) begin : mon
    rsp_t e;
    if (rsp_valid) begin
      e.c = cyc; e.id = rsp_id; e.tag = rsp_tag; e.res = rsp_result; e.err = rsp_err;
      rsp_q.push_back(e);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", nm, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_req(input int p, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] tg);
    req_valid[p] = 1'b1;
    req_op[p]    = op;
    req_opa[p]   = a;
    req_opb[p]   = b;
    req_tag[p]   = tg;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic wait_rsps(input int n, input int lim);
    for (int i = 0; i < lim; i++) begin
      if (rsp_q.size() >= n) break;
      tick();
    end
    chk("rsp_count", 32'(rsp_q.size()), 32'(n));
  endtask

  task automatic check_rsp(input string nm, input int ec, input logic eid,
                           input logic [TAG_W-1:0] etag, input logic [31:0] eres,
                           input logic eerr);
    rsp_t e;
    if (rsp_q.size() == 0) begin
      chk({nm, "_missing"}, 32'd0, 32'd1);
      return;
    end
    e = rsp_q.pop_front();
    chk({nm, "_cyc"}, 32'(e.c), 32'(ec));
    chk({nm, "_id"},  32'(e.id), 32'(eid));
    chk({nm, "_tag"}, 32'(e.tag), 32'(etag));
    chk({nm, "_res"}, e.res, eres);
    chk({nm, "_err"}, 32'(e.err), 32'(eerr));
  endtask

  initial begin : main
    int s, t, a, b, r, n0;
    logic x0, x1;
    logic [1:0] exp_rdy;

    // Reset: readies must stay low even with both requesters valid.
    reset_n = 1'b0; req_valid = 2'b11; req_op = '0; req_opa = '0; req_opb = '0; req_tag = '0;
    tick(); tick(); mid();
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_dp_start", 32'(dp_start), 32'd0);
    chk("rst_dp_op", 32'(dp_op), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    req_valid = 2'b00; reset_n = 1'b1;
    tick();

    // Streaming round-robin: 8 muls, grants alternate starting at port 0.
    set_req(0, OP_MUL, 32'h3F80_0000, 32'h4000_0000, 4'd1);
    set_req(1, OP_MUL, 32'h3F80_0001, 32'h4000_0000, 4'd2);
    s = 0;
    for (int k = 0; k < 8; k++) begin
      mid();
      if (k == 0) s = cyc;
      chk($sformatf("strm_ready_k%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) begin
        chk($sformatf("strm_dp_start_k%0d", k), 32'(dp_start), 32'd1);
        chk($sformatf("strm_dp_opa_k%0d", k), dp_opa, 32'h3F80_0000 + 32'(k - 1));
      end
      tick();
      if (k + 2 < 8) set_req(k % 2, OP_MUL, 32'h3F80_0000 + 32'(k + 2), 32'h4000_0000, 4'(k + 3));
      else req_valid[k % 2] = 1'b0;
    end
    wait_rsps(8, 40);
    for (int k = 0; k < 8; k++) begin
      check_rsp($sformatf("strm%0d", k), s + 6 + k, 1'(k % 2), 4'(k + 1), stamp(s + 5 + k), 1'b0);
    end

    // Single mul with a fixed datapath answer.
    wait_idle();
    rsp_q.delete();
    set_req(0, OP_MUL, 32'h3FC0_0000, 32'h4000_0000, 4'd3);
    mid();
    t = cyc;
    dp_fix_cyc = t + 5;
    dp_fix_val = 32'h4040_0000;
    chk("mul_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    mid();
    chk("mul_dp_start", 32'(dp_start), 32'd1);
    chk("mul_dp_op", 32'(dp_op), 32'(OP_MUL));
    chk("mul_dp_opa", dp_opa, 32'h3FC0_0000);
    chk("mul_dp_opb", dp_opb, 32'h4000_0000);
    chk("mul_busy", 32'(busy), 32'd1);
    tick();
    wait_rsps(1, 20);
    check_rsp("mul", t + 6, 1'b0, 4'd3, 32'h4040_0000, 1'b0);
    wait_idle();
    chk("mul_single_pulse", 32'(rsp_q.size()), 32'd0);

    // Illegal opcode: multiply latency, err flagged.
    set_req(0, 3'b111, 32'h1234_5678, 32'h9ABC_DEF0, 4'd5);
    mid();
    t = cyc;
    chk("ill_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    mid();
    chk("ill_dp_op", 32'(dp_op), 32'd7);
    tick();
    wait_rsps(1, 20);
    check_rsp("ill", t + 6, 1'b0, 4'd5, stamp(t + 5), 1'b1);

    // Div behind three muls, then a mul held off until the div completes.
    wait_idle();
    rsp_q.delete();
    set_req(0, OP_MUL, 32'h4000_0000, 32'h4000_0000, 4'd1);
    a = 0; n0 = 0;
    for (int k = 0; k < 37; k++) begin
      mid();
      if (k == 0) a = cyc;
      exp_rdy = (k <= 2) ? 2'b01 : (k == 8) ? 2'b10 : (k == 36) ? 2'b01 : 2'b00;
      chk($sformatf("divq_ready_k%0d", k), 32'(req_ready), 32'(exp_rdy));
      x0 = req_valid[0] & req_ready[0];
      x1 = req_valid[1] & req_ready[1];
      tick();
      if (x0) begin
        n0++;
        if (n0 < 3) set_req(0, OP_MUL, 32'h4000_0000 + 32'(n0), 32'h4000_0000, 4'(n0 + 1));
        else req_valid[0] = 1'b0;
      end
      if (x1) req_valid[1] = 1'b0;
      if (k == 2) set_req(1, OP_DIV, 32'h4049_0FDB, 32'h4000_0000, 4'd9);
      if (k == 8) set_req(0, OP_MUL, 32'h4100_0000, 32'h4000_0000, 4'd4);
    end
    req_valid = 2'b00;
    wait_rsps(5, 20);
    check_rsp("divq_m1", a + 6, 1'b0, 4'd1, stamp(a + 5), 1'b0);
    check_rsp("divq_m2", a + 7, 1'b0, 4'd2, stamp(a + 6), 1'b0);
    check_rsp("divq_m3", a + 8, 1'b0, 4'd3, stamp(a + 7), 1'b0);
    check_rsp("divq_div", a + 8 + int'(DIV_LAT) + 2, 1'b1, 4'd9, stamp(a + 8 + int'(DIV_LAT) + 1), 1'b0);
    check_rsp("divq_m4", a + 42, 1'b0, 4'd4, stamp(a + 41), 1'b0);

    // Reset while two muls are in flight and a div is locked in DRAIN.
    wait_idle();
    rsp_q.delete();
    set_req(0, OP_MUL, 32'h4000_0000, 32'h4000_0000, 4'd1);
    mid();
    b = cyc;
    chk("rstf_ready0", 32'(req_ready), 32'd1);
    tick();
    set_req(0, OP_MUL, 32'h4040_0000, 32'h4000_0000, 4'd2);
    mid();
    chk("rstf_ready1", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, OP_DIV, 32'h4080_0000, 32'h4000_0000, 4'd7);
    mid();
    chk("rstf_ready2", 32'(req_ready), 32'd0);
    tick();
    mid();
    chk("rstf_drain_busy", 32'(busy), 32'd1);
    chk("rstf_cycle", 32'(cyc), 32'(b + 3));
    reset_n = 1'b0;
    #1;
    chk("rstf_ready", 32'(req_ready), 32'd0);
    chk("rstf_dp_start", 32'(dp_start), 32'd0);
    chk("rstf_dp_op", 32'(dp_op), 32'd0);
    chk("rstf_dp_opa", dp_opa, 32'd0);
    chk("rstf_dp_opb", dp_opb, 32'd0);
    chk("rstf_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstf_rsp_id", 32'(rsp_id), 32'd0);
    chk("rstf_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rstf_rsp_result", rsp_result, 32'd0);
    chk("rstf_rsp_err", 32'(rsp_err), 32'd0);
    chk("rstf_busy", 32'(busy), 32'd0);
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rstf_no_rsp_in_reset", 32'(rsp_q.size()), 32'd0);
    reset_n = 1'b1;
    set_req(0, OP_MUL, 32'h4080_0000, 32'h4000_0000, 4'd6);
    mid();
    r = cyc;
    chk("rstf_new_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid[0] = 1'b0;
    wait_rsps(1, 20);
    check_rsp("rstf_new", r + 6, 1'b0, 4'd6, stamp(r + 5), 1'b0);
    repeat (40) tick();
    chk("rstf_no_stale_rsp", 32'(rsp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fpu_muldiv_arb.md
Name: fpu_muldiv_arb

Overview:
- Controller and arbiter that shares one FMUL/FDIV datapath (pre-normalize, multiply/divide, post-normalize) between two requesters.
- Round-robin arbitration; issues operands to the datapath; tracks in-flight operations by latency; returns each result with its requester id and tag on a single response bus.
- Multiply is pipelined at one issue per cycle. Divide drains the pipeline first and then occupies the datapath exclusively.

Parameters:
- MUL_LAT, 4: cycles from dp_start to a valid dp_result for a multiply (1..15).
- DIV_LAT, 26: cycles from dp_start to a valid dp_result for a divide (1..63).
- TAG_W, 4: requester tag width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  request valid, one bit per requester.
- req_ready  out  2  request ready, one bit per requester.
- req_op  in  2x3  fpu_op per requester: 3'b010 = mul, 3'b011 = div, any other value is illegal.
- req_opa, req_opb  in  2x32  IEEE-754 single-precision operands per requester.
- req_tag  in  2xTAG_W  tag per requester.
- dp_start  out  1  issue strobe to the datapath.
- dp_op  out  3  opcode issued to the datapath.
- dp_opa, dp_opb  out  32  operands issued to the datapath.
- dp_result  in  32  datapath result.
- rsp_valid  out  1  response strobe; there is no backpressure on the response bus.
- rsp_id  out  1  requester index of the response.
- rsp_tag  out  TAG_W  tag of the response.
- rsp_result  out  32  result data.
- rsp_err  out  1  the completed operation had an illegal opcode.
- busy  out  1  high while any operation is in flight or the state is not IDLE.

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; in-flight count = 0; state = IDLE; tracking pipe cleared.
- Handshake:
  - A transfer occurs when req_valid[i] & req_ready[i].
  - At most one bit of req_ready is high in any cycle.
  - req_ready may depend on req_valid. Requesters must not make valid depend on ready.
  - Once valid is raised, a requester holds valid and its payload until the transfer.
- Arbitration:
  - Candidate = the valid port, with the rr pointer as tie-break when both are valid.
  - The pointer moves to the other port only on a transfer.
  - The candidate stays locked while it is stalled.
- Issue timing:
  - A transfer in cycle t drives dp_start=1 and registered dp_op/opa/opb in cycle t+1.
  - dp_op/opa/opb hold their values while dp_start=0.
- Completion timing:
  - The controller samples dp_result in cycle t+1+LAT, where LAT is MUL_LAT or DIV_LAT.
  - It drives rsp_valid=1 for exactly one cycle at t+2+LAT, with the sampled result, id, tag and err.
  - rsp_* fields other than rsp_valid are don't-care when rsp_valid=0.
- Illegal opcode: accepted and issued with multiply latency; rsp_err=1.
- In-flight tracking:
  - A shift register of depth MUL_LAT+1 carries {valid, id, tag, err}.
  - The in-flight counter increments on dp_start and decrements on each sample.
  - Increment and decrement in the same cycle leave the counter unchanged.
- FSM:
  - IDLE: no operations in flight.
    - Candidate is mul/illegal → accept and go to RUN.
    - Candidate is div → accept and go to DIV.
  - RUN: muls streaming, back-to-back accepts allowed.
    - Candidate is div → both readies low and go to DRAIN.
    - Counter reaches 0 with no accept → go to IDLE.
  - DRAIN: both readies low until the counter is 0 and dp_start is 0.
    - Then accept the locked div candidate that cycle and go to DIV.
  - DIV: both readies low. A down-counter loads DIV_LAT+1 on the dp_start cycle.
    - In the sample cycle, rsp is scheduled and the state goes to IDLE.
    - The next accept is allowed in the following cycle.
- No two results are ever sampled in the same cycle. Response order equals issue order.
- busy = (state != IDLE) | (counter != 0) | rsp_valid.
- Reset mid-operation: all in-flight operations are dropped with no response, and every register returns to its reset value immediately (asynchronous). The first accept is possible in the first clock edge after reset_n rises.

Test Plan:
- Single mul:
  - Stimulus: port0 mul, opa=0x3FC00000, opb=0x40000000, tag=3, accepted at t; datapath model returns 0x40400000 at the sample cycle.
  - Required: dp_start at t+1; rsp_valid at t+6 with id=0, tag=3, result=0x40400000, err=0.
- Streaming round-robin:
  - Stimulus: both ports continuously valid with muls, 8 transfers.
  - Required: grants alternate 0,1,0,1…; 8 responses on consecutive cycles in issue order with correct tags.
- Div behind muls:
  - Stimulus: port0 issues 3 muls back-to-back, port1 then presents a div.
  - Required: port1 ready stays low until the last mul has been sampled; the div is accepted that cycle; its response arrives DIV_LAT+2 cycles after acceptance.
  - Required: no accept on either port during DIV.
- Illegal opcode:
  - Stimulus: req_op=3'b111, tag=5.
  - Required: response at the multiply latency with rsp_err=1, tag=5.
- Reset mid-flight:
  - Stimulus: assert reset_n=0 while 2 muls are in flight and a div is locked in DRAIN.
  - Required: no rsp_valid ever appears for them; all outputs are 0 immediately; a new mul after release completes normally.
